// File: rtl/chirp_mon_pkg.sv
// Shared types and constants for the chirp monitor: FSM state encoding,
// NCO control word width and the muted-chirp gap ceiling.
package chirp_mon_pkg;

  localparam int CTRL_W  = 32;
  localparam int GAP_MAX = 15;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ARM,
    ST_MEASURE
  } state_e;

endpackage

// File: rtl/chirp_step_classify.sv
// Holds the previous NCO control sample and classifies the current one as
// up/down change with its unsigned delta; no change is reported until a first sample is held.
module chirp_step_classify
  import chirp_mon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              change_o,
  output logic              up_o,
  output logic              down_o,
  output logic [CTRL_W-1:0] delta_o,
  output logic [CTRL_W-1:0] prev_o
);

  logic [CTRL_W-1:0] prev_q;
  logic              prev_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= ctrl_i;
      prev_vld_q <= 1'b1;
    end
  end

  assign up_o     = prev_vld_q && (ctrl_i > prev_q);
  assign down_o   = prev_vld_q && (ctrl_i < prev_q);
  assign change_o = up_o | down_o;
  assign delta_o  = up_o ? (ctrl_i - prev_q) : (prev_q - ctrl_i);
  assign prev_o   = prev_q;

endmodule

// File: rtl/chirp_monitor.sv
// Passive NCO-control observer: locks the sweep direction, then reports start/end/step/interval/length/muting
// one cycle after each wrap. Define CHIRP_MON_CHECK_EN to build the sticky step-consistency flag on err.
module chirp_monitor
  import chirp_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nco_reset,
  input  logic [CTRL_W-1:0] nco_ctrl,
  output logic              locked,
  output logic              rpt_valid,
  output logic              rpt_is_down,
  output logic [CTRL_W-1:0] rpt_start,
  output logic [CTRL_W-1:0] rpt_end,
  output logic [CTRL_W-1:0] rpt_step,
  output logic [CNT_W-1:0]  rpt_interval,
  output logic [CNT_W-1:0]  rpt_length,
  output logic              rpt_muted,
  output logic [3:0]        rpt_gap,
  output logic              err
);

  logic              change, up, down;
  logic [CTRL_W-1:0] delta, prev;

  chirp_step_classify u_classify (
    .clk      (clk),
    .rst      (rst),
    .ctrl_i   (nco_ctrl),
    .change_o (change),
    .up_o     (up),
    .down_o   (down),
    .delta_o  (delta),
    .prev_o   (prev)
  );

  state_e            state_q, state_d;
  logic              dir_down_q, dir_down_d;
  logic              pair_vld_q, pair_vld_d;
  logic              pair_down_q, pair_down_d;
  logic              locked_q, locked_d;
  logic [CTRL_W-1:0] start_q, start_d;
  logic [CTRL_W-1:0] step_q, step_d;
  logic              has_step_q, has_step_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  int_cnt_q, int_cnt_d;
  logic [CNT_W-1:0]  ival_q, ival_d;
  logic              muted_q, muted_d;
  logic [3:0]        gap_q, gap_d;
  logic              rpt_valid_q, rpt_valid_d;
  logic              rpt_is_down_q, rpt_is_down_d;
  logic [CTRL_W-1:0] rpt_start_q, rpt_start_d;
  logic [CTRL_W-1:0] rpt_end_q, rpt_end_d;
  logic [CTRL_W-1:0] rpt_step_q, rpt_step_d;
  logic [CNT_W-1:0]  rpt_interval_q, rpt_interval_d;
  logic [CNT_W-1:0]  rpt_length_q, rpt_length_d;
  logic              rpt_muted_q, rpt_muted_d;
  logic [3:0]        rpt_gap_q, rpt_gap_d;
  logic              start_chirp;
  logic              same, opp;
`ifdef CHIRP_MON_CHECK_EN
  logic              err_q, err_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Step/wrap are relative to the locked direction.
  assign same = dir_down_q ? down : up;
  assign opp  = dir_down_q ? up : down;

  always_comb begin
    state_d        = state_q;
    dir_down_d     = dir_down_q;
    pair_vld_d     = pair_vld_q;
    pair_down_d    = pair_down_q;
    locked_d       = locked_q;
    start_d        = start_q;
    step_d         = step_q;
    has_step_d     = has_step_q;
    len_d          = len_q;
    int_cnt_d      = int_cnt_q;
    ival_d         = ival_q;
    muted_d        = muted_q;
    gap_d          = gap_q;
    rpt_valid_d    = 1'b0;
    rpt_is_down_d  = rpt_is_down_q;
    rpt_start_d    = rpt_start_q;
    rpt_end_d      = rpt_end_q;
    rpt_step_d     = rpt_step_q;
    rpt_interval_d = rpt_interval_q;
    rpt_length_d   = rpt_length_q;
    rpt_muted_d    = rpt_muted_q;
    rpt_gap_d      = rpt_gap_q;
    start_chirp    = 1'b0;
`ifdef CHIRP_MON_CHECK_EN
    err_d          = err_q;
`endif

    case (state_q)
      ST_HUNT: begin
        if (change) begin
          if (pair_vld_q && (pair_down_q == down)) begin
            dir_down_d = down;
            state_d    = ST_ARM;
          end else begin
            pair_vld_d  = 1'b1;
            pair_down_d = down;
          end
        end
      end
      ST_ARM: begin
        if (opp) begin
          state_d     = ST_MEASURE;
          locked_d    = 1'b1;
          start_chirp = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (opp) begin
          rpt_valid_d    = 1'b1;
          rpt_is_down_d  = dir_down_q;
          rpt_start_d    = start_q;
          rpt_end_d      = prev;
          rpt_step_d     = has_step_q ? step_q : '0;
          rpt_interval_d = has_step_q ? ival_q : len_q;
          rpt_length_d   = len_q;
          rpt_muted_d    = muted_q;
          if (muted_q) begin
            rpt_gap_d = 4'd0;
            gap_d     = (gap_q == 4'(GAP_MAX)) ? gap_q : gap_q + 4'd1;
          end else begin
            rpt_gap_d = gap_q;
            gap_d     = 4'd0;
          end
          start_chirp = 1'b1;
        end else begin
          len_d = sat_inc(len_q);
          if (same) begin
`ifdef CHIRP_MON_CHECK_EN
            if (has_step_q && (delta != step_q)) err_d = 1'b1;
`endif
            if (!has_step_q) step_d = delta;
            has_step_d = 1'b1;
            ival_d     = int_cnt_q;
            int_cnt_d  = CNT_W'(1);
          end else begin
            int_cnt_d = sat_inc(int_cnt_q);
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // The wrap sample is the first sample of the next chirp.
    if (start_chirp) begin
      start_d    = nco_ctrl;
      len_d      = CNT_W'(1);
      int_cnt_d  = CNT_W'(1);
      has_step_d = 1'b0;
      step_d     = '0;
      muted_d    = nco_reset;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      dir_down_q     <= 1'b0;
      pair_vld_q     <= 1'b0;
      pair_down_q    <= 1'b0;
      locked_q       <= 1'b0;
      start_q        <= '0;
      step_q         <= '0;
      has_step_q     <= 1'b0;
      len_q          <= '0;
      int_cnt_q      <= '0;
      ival_q         <= '0;
      muted_q        <= 1'b0;
      gap_q          <= 4'd0;
      rpt_valid_q    <= 1'b0;
      rpt_is_down_q  <= 1'b0;
      rpt_start_q    <= '0;
      rpt_end_q      <= '0;
      rpt_step_q     <= '0;
      rpt_interval_q <= '0;
      rpt_length_q   <= '0;
      rpt_muted_q    <= 1'b0;
      rpt_gap_q      <= 4'd0;
    end else begin
      state_q        <= state_d;
      dir_down_q     <= dir_down_d;
      pair_vld_q     <= pair_vld_d;
      pair_down_q    <= pair_down_d;
      locked_q       <= locked_d;
      start_q        <= start_d;
      step_q         <= step_d;
      has_step_q     <= has_step_d;
      len_q          <= len_d;
      int_cnt_q      <= int_cnt_d;
      ival_q         <= ival_d;
      muted_q        <= muted_d;
      gap_q          <= gap_d;
      rpt_valid_q    <= rpt_valid_d;
      rpt_is_down_q  <= rpt_is_down_d;
      rpt_start_q    <= rpt_start_d;
      rpt_end_q      <= rpt_end_d;
      rpt_step_q     <= rpt_step_d;
      rpt_interval_q <= rpt_interval_d;
      rpt_length_q   <= rpt_length_d;
      rpt_muted_q    <= rpt_muted_d;
      rpt_gap_q      <= rpt_gap_d;
    end
  end

`ifdef CHIRP_MON_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign locked       = locked_q;
  assign rpt_valid    = rpt_valid_q;
  assign rpt_is_down  = rpt_is_down_q;
  assign rpt_start    = rpt_start_q;
  assign rpt_end      = rpt_end_q;
  assign rpt_step     = rpt_step_q;
  assign rpt_interval = rpt_interval_q;
  assign rpt_length   = rpt_length_q;
  assign rpt_muted    = rpt_muted_q;
  assign rpt_gap      = rpt_gap_q;

endmodule

// File: tb/tb_chirp_monitor.sv
// Bench for chirp_monitor: directed scenarios plus biased random sweeps, checked every cycle
// against a chirp-level reference model that derives each report from the stored sample list.
module tb_chirp_monitor;

  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk, rst, nco_reset;
  logic [31:0]      nco_ctrl;
  logic             locked, rpt_valid, rpt_is_down, rpt_muted, err;
  logic [31:0]      rpt_start, rpt_end, rpt_step;
  logic [CNT_W-1:0] rpt_interval, rpt_length;
  logic [3:0]       rpt_gap;

  chirp_monitor #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .nco_reset    (nco_reset),
    .nco_ctrl     (nco_ctrl),
    .locked       (locked),
    .rpt_valid    (rpt_valid),
    .rpt_is_down  (rpt_is_down),
    .rpt_start    (rpt_start),
    .rpt_end      (rpt_end),
    .rpt_step     (rpt_step),
    .rpt_interval (rpt_interval),
    .rpt_length   (rpt_length),
    .rpt_muted    (rpt_muted),
    .rpt_gap      (rpt_gap),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state: mode 0 hunting, 1 armed, 2 measuring.
  bit          m_have_prev, m_have_one, m_last_up, m_dir_down, m_muted, m_err, m_has_first;
  logic [31:0] m_prev, m_first;
  int          m_mode, m_gap;
  logic [31:0] m_chirp[$];
  bit          e_valid, e_is_down, e_muted;
  logic [31:0] e_start, e_end, e_step;
  int          e_interval, e_length, e_gap;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_reset();
    m_have_prev = 0; m_have_one = 0; m_last_up = 0; m_dir_down = 0;
    m_muted = 0; m_err = 0; m_has_first = 0; m_prev = 0; m_first = 0;
    m_mode = 0; m_gap = 0; m_chirp.delete();
    e_valid = 0; e_is_down = 0; e_muted = 0; e_start = 0; e_end = 0;
    e_step = 0; e_interval = 0; e_length = 0; e_gap = 0;
  endtask

  task automatic model_report();
    int k, j;
    k = -1; j = 0;
    e_valid   = 1;
    e_is_down = m_dir_down;
    e_start   = m_chirp[0];
    e_end     = m_chirp[m_chirp.size()-1];
    e_length  = sat(m_chirp.size());
    e_step    = 0;
    for (int i = 1; i < m_chirp.size(); i++) begin
      if (m_chirp[i] != m_chirp[i-1]) begin
        if (k < 0) e_step = m_dir_down ? m_chirp[i-1] - m_chirp[i] : m_chirp[i] - m_chirp[i-1];
        j = (k < 0) ? 0 : k;
        k = i;
      end
    end
    e_interval = (k < 0) ? e_length : sat(k - j);
    e_muted    = m_muted;
    if (m_muted) begin
      e_gap = 0;
      if (m_gap < 15) m_gap++;
    end else begin
      e_gap = m_gap;
      m_gap = 0;
    end
  endtask

  task automatic new_chirp(input logic [31:0] w, input bit r);
    m_chirp.delete();
    m_chirp.push_back(w);
    m_muted     = r;
    m_has_first = 0;
  endtask

  task automatic model_cycle(input logic [31:0] w, input bit r);
    bit chg, up, opp;
    logic [31:0] d;
    chg = m_have_prev && (w != m_prev);
    up  = (w > m_prev);
    opp = chg && (up == m_dir_down);
    d   = up ? w - m_prev : m_prev - w;
    e_valid = 0;
    case (m_mode)
      0: if (chg) begin
        if (m_have_one && (m_last_up == up)) begin
          m_dir_down = !up;
          m_mode = 1;
        end else begin
          m_have_one = 1;
          m_last_up = up;
        end
      end
      1: if (opp) begin
        m_mode = 2;
        new_chirp(w, r);
      end
      default: if (opp) begin
        model_report();
        new_chirp(w, r);
      end else begin
        if (chg) begin
          if (m_has_first && (d != m_first)) m_err = 1;
          if (!m_has_first) begin
            m_has_first = 1;
            m_first = d;
          end
        end
        m_chirp.push_back(w);
      end
    endcase
    m_have_prev = 1;
    m_prev = w;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    rpt_valid,    e_valid);
    chk({tag, ".locked"},   locked,       m_mode == 2);
    chk({tag, ".is_down"},  rpt_is_down,  e_is_down);
    chk({tag, ".start"},    rpt_start,    e_start);
    chk({tag, ".end"},      rpt_end,      e_end);
    chk({tag, ".step"},     rpt_step,     e_step);
    chk({tag, ".interval"}, rpt_interval, e_interval);
    chk({tag, ".length"},   rpt_length,   e_length);
    chk({tag, ".muted"},    rpt_muted,    e_muted);
    chk({tag, ".gap"},      rpt_gap,      e_gap);
`ifdef CHIRP_MON_CHECK_EN
    chk({tag, ".err"},      err,          m_err);
`else
    chk({tag, ".err"},      err,          0);
`endif
  endtask

  task automatic tick(input logic [31:0] w, input bit r = 0);
    nco_ctrl  = w;
    nco_reset = r;
    model_cycle(w, r);
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("arst");
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] cur;
    int p;
    checks = 0; errors = 0;
    rst = 1'b1; nco_reset = 1'b0; nco_ctrl = '0;
    model_reset();
    #3;
    check_all("por");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Up sweep twice, then wrap.
    for (int rep = 0; rep < 2; rep++) begin
      tick(100); tick(100); tick(120); tick(120); tick(140); tick(140); tick(160);
    end
    tick(100);
    chk("up.valid", rpt_valid, 1);   chk("up.start", rpt_start, 100);
    chk("up.end", rpt_end, 160);     chk("up.step", rpt_step, 20);
    chk("up.ival", rpt_interval, 2); chk("up.len", rpt_length, 7);
    chk("up.dir", rpt_is_down, 0);
    tick(100);
    chk("up.strobe", rpt_valid, 0);

    // Down sweep twice, then wrap.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      tick(500); tick(450); tick(400);
    end
    tick(500);
    chk("dn.valid", rpt_valid, 1);   chk("dn.dir", rpt_is_down, 1);
    chk("dn.start", rpt_start, 500); chk("dn.end", rpt_end, 400);
    chk("dn.step", rpt_step, 50);    chk("dn.ival", rpt_interval, 1);
    chk("dn.len", rpt_length, 3);

    // Three muted chirps, then an unmuted one.
    do_reset();
    tick(10); tick(20); tick(30);
    for (int i = 0; i < 5; i++) begin
      tick(10, i < 3);
      if (i > 0) begin
        chk("mute.valid", rpt_valid, 1);
        chk("mute.flag", rpt_muted, i <= 3);
        chk("mute.gap", rpt_gap, (i == 4) ? 3 : 0);
      end
      tick(20); tick(30);
    end

    // Inconsistent step 20,20,30, then reset mid-chirp.
    do_reset();
    tick(0); tick(20); tick(40); tick(0);
    tick(20); tick(40);
    chk("err.pre", err, 0);
    tick(70);
`ifdef CHIRP_MON_CHECK_EN
    chk("err.rise", err, 1);
`else
    chk("err.rise", err, 0);
`endif
    tick(70); tick(0); tick(20); tick(40);
    do_reset();
    tick(5); tick(10);
    chk("relock.a", locked, 0);
    tick(20);
    chk("relock.b", locked, 0);
    tick(5);
    chk("relock.c", locked, 1);
    chk("relock.norpt", rpt_valid, 0);

    // Long constant chirp saturates length.
    do_reset();
    tick(1000); tick(1001); tick(1002); tick(1000);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick(1000);
    tick(500);
    chk("sat.valid", rpt_valid, 1);
    chk("sat.len", rpt_length, SAT);
    chk("sat.ival", rpt_interval, SAT);

    // Back-to-back wraps give length-1 chirps.
    do_reset();
    tick(100); tick(200); tick(300); tick(50); tick(40);
    chk("b2b.len1", rpt_length, 1);
    tick(30);
    chk("b2b.valid", rpt_valid, 1);
    chk("b2b.len2", rpt_length, 1);

    // Biased random sweeps in both directions.
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      cur = $urandom_range(1000, 5000);
      for (int i = 0; i < 500; i++) begin
        p = $urandom_range(0, 9);
        if (p >= 5 && p <= 7)  cur = blk[0] ? cur - 50 : cur + 50;
        else if (p == 8)       cur = blk[0] ? cur - $urandom_range(1, 99) : cur + $urandom_range(1, 99);
        else if (p == 9)       cur = blk[0] ? $urandom_range(6000, 6100) : $urandom_range(0, 100);
        tick(cur, $urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
